// File: rtl/tile_addr_gen_2d_if.sv
// Config, issue and data-address bundle for the 2D tile address generator.
// master = router controller side, slave = generator side.
interface tile_addr_gen_2d_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DIM_WIDTH  = 6
);
    logic                  i_start;
    logic                  i_clear;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [DIM_WIDTH-1:0]  i_num_rows;
    logic [DIM_WIDTH-1:0]  i_num_cols;
    logic [ADDR_WIDTH-1:0] i_row_stride;
    logic [DIM_WIDTH-1:0]  i_num_passes;
    logic                  i_ready;
    logic                  o_busy;
    logic                  o_buf_read_en;
    logic [ADDR_WIDTH-1:0] o_read_addr;
    logic                  o_valid;
    logic [ADDR_WIDTH-1:0] o_data_addr;
    logic                  o_last;
    logic                  o_done;

    modport master (
        output i_start, i_clear, i_base_addr, i_num_rows, i_num_cols,
        output i_row_stride, i_num_passes, i_ready,
        input  o_busy, o_buf_read_en, o_read_addr, o_valid,
        input  o_data_addr, o_last, o_done
    );

    modport slave (
        input  i_start, i_clear, i_base_addr, i_num_rows, i_num_cols,
        input  i_row_stride, i_num_passes, i_ready,
        output o_busy, o_buf_read_en, o_read_addr, o_valid,
        output o_data_addr, o_last, o_done
    );
endinterface

// File: rtl/tile_addr_gen_2d.sv
// 2D tile address walker: rows x cols with row stride, repeated over passes.
// Issues buffer reads and tags returning data after READ_LATENCY cycles.
module tile_addr_gen_2d #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DIM_WIDTH    = 6,
    parameter int READ_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    tile_addr_gen_2d_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cfg_base;
    logic [ADDR_WIDTH-1:0] cfg_stride;
    logic [DIM_WIDTH-1:0]  cfg_rows;
    logic [DIM_WIDTH-1:0]  cfg_cols;
    logic [DIM_WIDTH-1:0]  cfg_passes;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [DIM_WIDTH-1:0]  col;
    logic [DIM_WIDTH-1:0]  row;
    logic [DIM_WIDTH-1:0]  pass;
    logic                  done_q;

    logic                  pipe_v [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_a [READ_LATENCY];
    logic                  pipe_l [READ_LATENCY];

    logic issue;
    logic last_col;
    logic last_row;
    logic last_pass;
    logic issue_last;
    logic early_busy;

    // Issue decode and end-of-dimension flags from registered state
    always_comb begin
        issue      = (state == S_RUN) && bus.i_ready;
        last_col   = (col == cfg_cols - 1'b1);
        last_row   = (row == cfg_rows - 1'b1);
        last_pass  = (pass == cfg_passes - 1'b1);
        issue_last = issue && last_col && last_row && last_pass;
        early_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            early_busy = early_busy | pipe_v[i];
        end
    end

    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_buf_read_en = issue;
    assign bus.o_read_addr   = addr_reg;
    assign bus.o_valid       = pipe_v[READ_LATENCY-1];
    assign bus.o_data_addr   = pipe_a[READ_LATENCY-1];
    assign bus.o_last        = pipe_l[READ_LATENCY-1];
    assign bus.o_done        = done_q;

    // FSM, tile counters and the read-latency pipeline
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_clear) begin
            state      <= S_IDLE;
            cfg_base   <= '0;
            cfg_stride <= '0;
            cfg_rows   <= '0;
            cfg_cols   <= '0;
            cfg_passes <= '0;
            addr_reg   <= '0;
            row_base   <= '0;
            col        <= '0;
            row        <= '0;
            pass       <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_l[i] <= 1'b0;
            end
        end else begin
            // Address stages only load on a valid so the output holds
            pipe_v[0] <= issue;
            pipe_l[0] <= issue_last;
            if (issue) begin
                pipe_a[0] <= addr_reg;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
                if (pipe_v[i-1]) begin
                    pipe_a[i] <= pipe_a[i-1];
                end
            end
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        cfg_base   <= bus.i_base_addr;
                        cfg_stride <= bus.i_row_stride;
                        cfg_rows   <= bus.i_num_rows;
                        cfg_cols   <= bus.i_num_cols;
                        cfg_passes <= bus.i_num_passes;
                        addr_reg   <= bus.i_base_addr;
                        row_base   <= bus.i_base_addr;
                        col        <= '0;
                        row        <= '0;
                        pass       <= '0;
                        if (bus.i_num_rows == '0 || bus.i_num_cols == '0 ||
                            bus.i_num_passes == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (!last_col) begin
                            col      <= col + 1'b1;
                            addr_reg <= addr_reg + 1'b1;
                        end else if (!last_row) begin
                            col      <= '0;
                            row      <= row + 1'b1;
                            row_base <= row_base + cfg_stride;
                            addr_reg <= row_base + cfg_stride;
                        end else if (!last_pass) begin
                            col      <= '0;
                            row      <= '0;
                            pass     <= pass + 1'b1;
                            row_base <= cfg_base;
                            addr_reg <= cfg_base;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!early_busy) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tile_addr_gen_2d.md
Name: tile_addr_gen_2d

Overview:
- Parametrised successor to the linear tile address counter in the sequential input router.
- Walks a 2D tile (rows x cols, programmable row stride) inside an activation/weight buffer, optionally over several passes.
- Drives buffer read-enable/address, and emits a valid-qualified data address aligned to a configurable buffer read latency.
- Sits between the router controller and the SRAM buffer. Downstream back-pressure is supported through i_ready.

Parameters:
ADDR_WIDTH, 8, buffer address width; all address arithmetic is modulo 2^ADDR_WIDTH
DIM_WIDTH, 6, width of row/col/pass count fields
READ_LATENCY, 1, buffer read latency in cycles (>=1); delay applied to o_valid/o_data_addr/o_last

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_clear  in  1  synchronous abort to IDLE
i_base_addr  in  ADDR_WIDTH  first address of tile
i_num_rows  in  DIM_WIDTH  row count (0 = empty tile)
i_num_cols  in  DIM_WIDTH  column count (0 = empty tile)
i_row_stride  in  ADDR_WIDTH  address increment between row starts
i_num_passes  in  DIM_WIDTH  times the full tile is re-read (0 = empty)
i_ready  in  1  downstream can accept an issue this cycle
o_busy  out  1  state != IDLE
o_buf_read_en  out  1  buffer read strobe
o_read_addr  out  ADDR_WIDTH  buffer read address
o_valid  out  1  buffer data for o_data_addr is valid
o_data_addr  out  ADDR_WIDTH  address of data now on buffer output
o_last  out  1  with o_valid, marks final element of final pass
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset/clear: i_rst has priority over i_clear, and i_clear over i_start. Either one forces IDLE, zeroes all counters, flushes the latency pipeline, and sets every output to 0 on the next edge. Both are legal mid-operation; in-flight valids are discarded.
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE: on i_start, latch all config inputs (later changes are ignored until the next start).
  - If any of rows/cols/passes is 0, go to DONE.
  - Otherwise go to RUN with addr_reg = row_base = i_base_addr and row/col/pass counters = 0.
- RUN issue: o_buf_read_en = (state==RUN) & i_ready, combinational from registered state. o_read_addr = addr_reg, registered.
  - When i_ready is low, nothing is issued and all counters hold.
- Advance on each issue:
  - col != cols-1: col++, addr_reg++.
  - Else, row != rows-1: col = 0, row++, row_base += stride, addr_reg = row_base + stride.
  - Else, pass != passes-1: col = row = 0, pass++, row_base = addr_reg = latched base.
  - Else (final element): go to DRAIN.
- Wrap: all address sums truncate to ADDR_WIDTH; no saturation and no error flag.
- Pipeline: a READ_LATENCY-deep shift register of {issue, addr, last}. It always advances and does not stall on i_ready. o_valid, o_data_addr and o_last are its output stage.
  - Each issue at cycle t yields o_valid at t+READ_LATENCY.
  - Downstream must absorb up to READ_LATENCY in-flight elements after deasserting i_ready.
- DRAIN: no issues. Leave when the pipeline is empty, i.e. the cycle after the last o_valid; go to DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE. For an empty tile, o_done is asserted 1 cycle after the start edge, with no reads.
- i_start outside IDLE is ignored; o_busy stays 1.
- Timing: start sampled at edge E0 -> first possible o_buf_read_en in the cycle after E0. Total issues = rows*cols*passes. With i_ready held high, o_done comes READ_LATENCY+1 cycles after the final issue cycle.
- o_data_addr holds its last value when o_valid = 0. After reset/clear it is 0.

Test Plan:
- Basic 2D: base=10, rows=2, cols=3, stride=8, passes=1, LAT=1, ready=1 -> read addrs 10,11,12,18,19,20 on 6 consecutive cycles; o_data_addr same sequence one cycle later; o_last only with 20; single o_done; o_busy low afterwards.
- Back-pressure: same config, i_ready low on 3rd and 4th issue cycles -> no read_en during stall; address sequence unchanged and no duplicates or skips; exactly 6 o_valid.
- Wrap and passes: ADDR_WIDTH=8, base=254, rows=1, cols=4, passes=2 -> 254,255,0,1,254,255,0,1; o_last only on the final 1.
- Empty tile: cols=0 (rows=2, passes=1) -> no read_en, no o_valid, o_done high exactly 1 cycle after start edge.
- Abort: i_clear two cycles into the basic 2D run, with i_start asserted in the same cycle -> IDLE next cycle; all outputs 0; no o_done; pipeline valids suppressed. A subsequent clean start reproduces the full basic sequence.
- Latency/priority: READ_LATENCY=3, basic config -> o_valid lags read_en by 3 cycles. i_start pulsed during RUN is ignored. i_rst mid-DRAIN -> all outputs 0 next cycle.
